serial_divider: RTL

Iterative restoring divider that computes one quotient bit per clock. It is the inverse companion of the serial shift-add multiplier and uses the same operand-strobe/done handshake, so a bench or a datapath controller can drive either block the same way. Typical use: checking multiplier results by division, and any datapath that needs a small unsigned quotient and remainder without a combinational divider.

---
 rtl/serial_divider.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_divider.sv
// Iterative restoring divider: one quotient bit per clock, start/done handshake.
// Optional SERIAL_DIV_DBZ_EN: fast-path zero divisor with a div_by_zero flag.
module serial_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  // The restored remainder is always below D, so its top bit is never set
  // between iterations; only the shifted value needs the extra bit.
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t_diff;
  logic [WIDTH-1:0] q_shift;

`ifdef SERIAL_DIV_DBZ_EN
  logic dbz_q, dbz_d;
  logic dbz_pend_q, dbz_pend_d;
`endif

  always_comb begin
    r_shift     = {r_q, q_q[WIDTH-1]};
    t_diff      = r_shift - {1'b0, d_q};
    q_shift     = {q_q[WIDTH-2:0], ~t_diff[WIDTH]};

    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef SERIAL_DIV_DBZ_EN
    dbz_d       = dbz_q;
    dbz_pend_d  = dbz_pend_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (Enable) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = CALC;
`ifdef SERIAL_DIV_DBZ_EN
          dbz_d      = 1'b0;
          dbz_pend_d = (divisor == '0);
`endif
        end
      end
      CALC: begin
`ifdef SERIAL_DIV_DBZ_EN
        if (dbz_pend_q) begin
          quotient_d  = '1;
          remainder_d = q_q;
          dbz_d       = 1'b1;
          dbz_pend_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = DONE;
        end else
`endif
        begin
          q_d   = q_shift;
          r_d   = t_diff[WIDTH] ? r_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            quotient_d  = q_d;
            remainder_d = r_d;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_DIV_DBZ_EN
      dbz_q       <= 1'b0;
      dbz_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SERIAL_DIV_DBZ_EN
      dbz_q       <= dbz_d;
      dbz_pend_q  <= dbz_pend_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef SERIAL_DIV_DBZ_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
